pulse_period_meter: RTL

- Receive-side counterpart of the team's enable-pulse generators.
- Accepts a pulse train, e.g. a divider's enable_pulse or an external strobe, and measures the clk-cycle count between consecutive rising edges.
- Delivers each measurement over a valid/ready output interface.
- Used for divider self-check, frequency readback and external clock-rate monitoring.

---
 rtl/pulse_period_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle distance between consecutive rising edges of pulse_in
// and hands each result out over valid/ready. Define PULSE_PERIOD_METER_AVG_EN to report the mean of every four periods.
module pulse_period_meter #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   pulse_in,
    output logic [COUNT_WIDTH-1:0] period_out,
    output logic                   period_valid,
    input  logic                   period_ready,
    output logic                   overflow,
    output logic                   overrun
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   s_cur;
    logic                   s_d_reg;
    logic                   rise;
    logic                   capture;
    logic                   result_load;
    logic [COUNT_WIDTH-1:0] result_value;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_cur = pulse_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            // Synchronizer keeps running while disabled so re-enabling sees clean history.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                    sync_reg[0] <= pulse_in;
                end
            end

            assign s_cur = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_reg <= 1'b0;
        end else begin
            s_d_reg <= s_cur;
        end
    end

    assign rise    = s_cur & ~s_d_reg;
    // count_reg already holds all-ones when saturated, so it is the captured value as-is.
    assign capture = enable & (state_reg == MEASURE) & rise;

`ifdef PULSE_PERIOD_METER_AVG_EN
    logic [COUNT_WIDTH+1:0] sum_reg;
    logic [COUNT_WIDTH+1:0] sum_next;
    logic [1:0]             avg_cnt_reg;

    assign sum_next     = sum_reg + {2'b00, count_reg};
    assign result_load  = capture & (avg_cnt_reg == 2'd3);
    assign result_value = sum_next[COUNT_WIDTH+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg     <= '0;
            avg_cnt_reg <= 2'd0;
        end else if (!enable) begin
            sum_reg     <= '0;
            avg_cnt_reg <= 2'd0;
        end else if (capture) begin
            sum_reg     <= (avg_cnt_reg == 2'd3) ? '0 : sum_next;
            avg_cnt_reg <= avg_cnt_reg + 2'd1;
        end
    end
`else
    assign result_load  = capture;
    assign result_value = count_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
        end else if (!enable) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    state_reg <= ARM;
                end
                ARM: begin
                    // The arming edge only starts the count; it has no predecessor.
                    if (rise) begin
                        state_reg <= MEASURE;
                        count_reg <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        count_reg <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    end else if (count_reg != CNT_MAX) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CNT_MAX - 1'b1) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
            endcase

            // A held result is never replaced; a new one is accepted only if the old one leaves now.
            if (result_load) begin
                if (!period_valid || period_ready) begin
                    period_out   <= result_value;
                    period_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule
